// File: rtl/onchip_mem_arbiter.sv
// Round-robin two-master arbiter for the single-port on-chip RAM, one access per clock.
// Optional statistics counters enabled by defining ONCHIP_ARB_STATS_EN.
module onchip_mem_arbiter #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
`ifdef ONCHIP_ARB_STATS_EN
   ,
   input  logic              stats_clear,
   output logic [31:0]       m0_grant_count,
   output logic [31:0]       m1_grant_count,
   output logic [31:0]       conflict_count
`endif
);

   logic              w_req0, w_req1, w_allow;
   logic              w_grant0, w_grant1, w_grant, w_wr, w_issue_rd;
   logic              w_last_grant_nxt;
   logic              r_last_grant;
   logic              r_tag_valid, r_tag_master;
   logic              r_rdv0, r_rdv1;
   logic [DATA_W-1:0] r_rd0, r_rd1;

   // Grant, issue mux and round-robin next state.
   always_comb begin
      w_req0           = m0_read | m0_write;
      w_req1           = m1_read | m1_write;
      w_allow          = ~freeze & ~reset;
      w_grant0         = w_allow & w_req0 & (~w_req1 | r_last_grant);
      w_grant1         = w_allow & w_req1 & (~w_req0 | ~r_last_grant);
      w_grant          = w_grant0 | w_grant1;
      w_wr             = (w_grant0 & m0_write) | (w_grant1 & m1_write);
      w_issue_rd       = w_grant & ~w_wr;
      w_last_grant_nxt = r_last_grant;
      if (w_grant0)      w_last_grant_nxt = 1'b0;
      else if (w_grant1) w_last_grant_nxt = 1'b1;

      mem_chipselect   = w_grant;
      mem_write        = w_wr;
      mem_clken        = 1'b1;
      mem_address      = m0_address;
      mem_byteenable   = m0_byteenable;
      mem_writedata    = m0_writedata;
      if (w_grant1) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
      end
      m0_waitrequest   = w_req0 & ~w_grant0;
      m1_waitrequest   = w_req1 & ~w_grant1;
   end

   // Read tag pipeline and response registers; freeze never stalls in-flight reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_tag_valid  <= 1'b0;
         r_tag_master <= 1'b0;
         r_rdv0       <= 1'b0;
         r_rdv1       <= 1'b0;
         r_rd0        <= '0;
         r_rd1        <= '0;
      end else begin
         r_last_grant <= w_last_grant_nxt;
         r_tag_valid  <= w_issue_rd;
         r_tag_master <= w_grant1;
         r_rdv0       <= r_tag_valid & ~r_tag_master;
         r_rdv1       <= r_tag_valid & r_tag_master;
         if (r_tag_valid & ~r_tag_master) r_rd0 <= mem_readdata;
         if (r_tag_valid & r_tag_master)  r_rd1 <= mem_readdata;
      end
   end

   assign m0_readdata      = r_rd0;
   assign m1_readdata      = r_rd1;
   assign m0_readdatavalid = r_rdv0;
   assign m1_readdatavalid = r_rdv1;

   // Simultaneous read and write from one master is illegal; write wins in hardware.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_m0_rw: assert (!(m0_read && m0_write));
         a_m1_rw: assert (!(m1_read && m1_write));
      end
   end

`ifdef ONCHIP_ARB_STATS_EN
   localparam int unsigned CNT_W = 32;
   logic [CNT_W-1:0] r_m0_cnt, r_m1_cnt, r_conf_cnt;

   // Saturating counters; clear beats a simultaneous increment.
   always_ff @(posedge clk) begin
      if (reset || stats_clear) begin
         r_m0_cnt   <= '0;
         r_m1_cnt   <= '0;
         r_conf_cnt <= '0;
      end else begin
         if (w_grant0 && (r_m0_cnt != '1)) r_m0_cnt <= r_m0_cnt + CNT_W'(1);
         if (w_grant1 && (r_m1_cnt != '1)) r_m1_cnt <= r_m1_cnt + CNT_W'(1);
         if (w_req0 && w_req1 && (r_conf_cnt != '1)) r_conf_cnt <= r_conf_cnt + CNT_W'(1);
      end
   end

   assign m0_grant_count = r_m0_cnt;
   assign m1_grant_count = r_m1_cnt;
   assign conflict_count = r_conf_cnt;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural single-port RAM on the mem_* side.
module tb_onchip_mem_arbiter;

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   logic              clk = 1'b0;
   logic              reset, freeze;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0] mem_writedata, mem_readdata;
`ifdef ONCHIP_ARB_STATS_EN
   logic              stats_clear;
   logic [31:0]       m0_grant_count, m1_grant_count, conflict_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
      .clk(clk), .reset(reset), .freeze(freeze),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef ONCHIP_ARB_STATS_EN
      , .stats_clear(stats_clear), .m0_grant_count(m0_grant_count),
      .m1_grant_count(m1_grant_count), .conflict_count(conflict_count)
`endif
   );

   // RAM model: byte-enabled write at the edge, registered address, unregistered q.
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] ram_addr = '0;
   always @(posedge clk) begin
      if (mem_chipselect) begin
         ram_addr <= mem_address;
         if (mem_write)
            for (int b = 0; b < int'(BE_W); b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
   end
   assign mem_readdata = ram[ram_addr];

   typedef struct packed {
      logic              frz, r0, w0, r1, w1;
      logic              ew0, ew1, ecs, emw;
      logic [ADDR_W-1:0] eaddr;
      logic [DATA_W-1:0] ewd;
   } vec_t;
   vec_t vt [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic idle();
      freeze = 1'b0; reset = 1'b0;
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
`ifdef ONCHIP_ARB_STATS_EN
      stats_clear = 1'b0;
`endif
   endtask

   task automatic m0_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      next_cyc(); idle();
      m0_write = 1'b1; m0_address = a; m0_writedata = d; m0_byteenable = 4'hF;
      mid();
      chk("preload wait0", 32'(m0_waitrequest), 32'd0);
   endtask

   int acc0, acc1;
   logic e0, e1;

   initial begin
      idle();
      m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
      m0_byteenable = 4'hF; m1_byteenable = 4'hF;

      // Reset with m0 requesting: no grant, waitrequest high, responses cleared.
      reset = 1'b1; m0_read = 1'b1;
      repeat (2) @(posedge clk);
      #1; mid();
      chk("reset wait0", 32'(m0_waitrequest), 32'd1);
      chk("reset cs", 32'(mem_chipselect), 32'd0);
      chk("reset rdv0", 32'(m0_readdatavalid), 32'd0);
      chk("reset rdv1", 32'(m1_readdatavalid), 32'd0);
      chk("reset rd0", m0_readdata, 32'd0);
      chk("reset rd1", m1_readdata, 32'd0);
      chk("reset clken", 32'(mem_clken), 32'd1);

      // Arbitration table: frz r0 w0 r1 w1 | wait0 wait1 cs mwr addr wdata
      vt[0]  = {5'b00000, 4'b0000, 18'h00100, 32'h11111111};
      vt[1]  = {5'b01010, 4'b0110, 18'h00100, 32'h11111111};
      vt[2]  = {5'b01010, 4'b1010, 18'h00200, 32'h22222222};
      vt[3]  = {5'b00001, 4'b0011, 18'h00200, 32'h22222222};
      vt[4]  = {5'b00110, 4'b0111, 18'h00100, 32'h11111111};
      vt[5]  = {5'b01000, 4'b0010, 18'h00100, 32'h11111111};
      vt[6]  = {5'b11010, 4'b1100, 18'h00100, 32'h11111111};
      vt[7]  = {5'b10010, 4'b0100, 18'h00100, 32'h11111111};
      vt[8]  = {5'b01010, 4'b1010, 18'h00200, 32'h22222222};
      vt[9]  = {5'b00100, 4'b0011, 18'h00100, 32'h11111111};
      vt[10] = {5'b00101, 4'b1011, 18'h00200, 32'h22222222};
      vt[11] = {5'b00000, 4'b0000, 18'h00100, 32'h11111111};
      for (int i = 0; i < 12; i++) begin
         next_cyc(); idle();
         m0_address = 18'h00100; m0_writedata = 32'h11111111; m0_byteenable = 4'hF;
         m1_address = 18'h00200; m1_writedata = 32'h22222222; m1_byteenable = 4'hF;
         freeze = vt[i].frz; m0_read = vt[i].r0; m0_write = vt[i].w0;
         m1_read = vt[i].r1; m1_write = vt[i].w1;
         mid();
         chk($sformatf("vec%0d wait0", i), 32'(m0_waitrequest), 32'(vt[i].ew0));
         chk($sformatf("vec%0d wait1", i), 32'(m1_waitrequest), 32'(vt[i].ew1));
         chk($sformatf("vec%0d cs", i), 32'(mem_chipselect), 32'(vt[i].ecs));
         chk($sformatf("vec%0d mwr", i), 32'(mem_write), 32'(vt[i].emw));
         chk($sformatf("vec%0d addr", i), 32'(mem_address), 32'(vt[i].eaddr));
         chk($sformatf("vec%0d wdata", i), mem_writedata, vt[i].ewd);
      end
      repeat (3) begin next_cyc(); idle(); end

      // m0 write then read of the same word, back to back.
      m0_wr(18'h00010, 32'hDEADBEEF);
      next_cyc(); idle(); m0_read = 1'b1; m0_address = 18'h00010; mid();
      chk("A rd wait0", 32'(m0_waitrequest), 32'd0);
      chk("A rdv0 +0", 32'(m0_readdatavalid), 32'd0);
      next_cyc(); idle(); mid();
      chk("A rdv0 +1", 32'(m0_readdatavalid), 32'd0);
      next_cyc(); idle(); mid();
      chk("A rdv0 +2", 32'(m0_readdatavalid), 32'd1);
      chk("A rd0", m0_readdata, 32'hDEADBEEF);
      next_cyc(); idle(); mid();
      chk("A rdv0 +3", 32'(m0_readdatavalid), 32'd0);

      // Preload, reset, then 8 cycles of continuous dual reads.
      for (int k = 0; k < 4; k++) m0_wr(ADDR_W'(32'h20 + k), 32'(32'hA0000000 + k));
      for (int k = 0; k < 4; k++) m0_wr(ADDR_W'(32'h40 + k), 32'(32'hB0000000 + k));
      next_cyc(); idle(); reset = 1'b1;
      acc0 = 0; acc1 = 0;
      for (int c = 0; c < 10; c++) begin
         next_cyc(); idle();
         if (c < 8) begin
            m0_read = 1'b1; m1_read = 1'b1;
            m0_address = ADDR_W'(32'h20 + (c + 1) / 2);
            m1_address = ADDR_W'(32'h40 + c / 2);
         end
         mid();
         if (c < 8) begin
            chk($sformatf("B%0d wait0", c), 32'(m0_waitrequest), 32'(c % 2));
            chk($sformatf("B%0d wait1", c), 32'(m1_waitrequest), 32'(1 - c % 2));
            if (!m0_waitrequest) acc0++;
            if (!m1_waitrequest) acc1++;
         end
         e0 = (c >= 2) && (c % 2 == 0);
         e1 = (c >= 3) && (c % 2 == 1);
         chk($sformatf("B%0d rdv0", c), 32'(m0_readdatavalid), 32'(e0));
         chk($sformatf("B%0d rdv1", c), 32'(m1_readdatavalid), 32'(e1));
         if (e0) chk($sformatf("B%0d rd0", c), m0_readdata, 32'(32'hA0000000 + (c - 2) / 2));
         if (e1) chk($sformatf("B%0d rd1", c), m1_readdata, 32'(32'hB0000000 + (c - 3) / 2));
      end
      chk("B acc0", 32'(acc0), 32'd4);
      chk("B acc1", 32'(acc1), 32'd4);

      // m1 partial write at the top address, then read back.
      m0_wr(18'h3FFFF, 32'h12345678);
      next_cyc(); idle();
      m1_write = 1'b1; m1_address = 18'h3FFFF; m1_byteenable = 4'h3; m1_writedata = 32'h0000AAAA;
      mid();
      chk("C wr wait1", 32'(m1_waitrequest), 32'd0);
      next_cyc(); idle(); m1_read = 1'b1; m1_byteenable = 4'hF; mid();
      chk("C rd wait1", 32'(m1_waitrequest), 32'd0);
      next_cyc(); idle(); mid();
      chk("C rdv1 +1", 32'(m1_readdatavalid), 32'd0);
      next_cyc(); idle(); mid();
      chk("C rdv1 +2", 32'(m1_readdatavalid), 32'd1);
      chk("C rd1", m1_readdata, 32'h1234AAAA);

      // Freeze right after an m1 read is issued.
      next_cyc(); idle(); m1_read = 1'b1; m1_address = 18'h00040; mid();
      chk("D issue wait1", 32'(m1_waitrequest), 32'd0);
      for (int c = 1; c < 3; c++) begin
         next_cyc(); idle(); freeze = 1'b1; m0_read = 1'b1; m1_read = 1'b1; mid();
         chk($sformatf("D%0d wait0", c), 32'(m0_waitrequest), 32'd1);
         chk($sformatf("D%0d wait1", c), 32'(m1_waitrequest), 32'd1);
         chk($sformatf("D%0d cs", c), 32'(mem_chipselect), 32'd0);
      end
      chk("D rdv1", 32'(m1_readdatavalid), 32'd1);
      chk("D rd1", m1_readdata, 32'hB0000000);
      next_cyc(); idle(); m0_read = 1'b1; m1_read = 1'b1; m0_address = 18'h00021; mid();
      chk("D rel wait0", 32'(m0_waitrequest), 32'd0);
      chk("D rel wait1", 32'(m1_waitrequest), 32'd1);
      next_cyc(); idle(); mid();
      next_cyc(); idle(); mid();
      chk("D rdv0", 32'(m0_readdatavalid), 32'd1);
      chk("D rd0", m0_readdata, 32'hA0000001);

      // Reset one cycle after an accepted read kills its response.
      next_cyc(); idle(); m0_read = 1'b1; m0_address = 18'h00022; mid();
      chk("E issue wait0", 32'(m0_waitrequest), 32'd0);
      next_cyc(); idle(); reset = 1'b1; m1_read = 1'b1; mid();
      chk("E rst wait1", 32'(m1_waitrequest), 32'd1);
      chk("E rst cs", 32'(mem_chipselect), 32'd0);
      next_cyc(); idle(); mid();
      chk("E rdv0", 32'(m0_readdatavalid), 32'd0);
      chk("E rd0", m0_readdata, 32'd0);
      chk("E rd1", m1_readdata, 32'd0);
      next_cyc(); idle(); m0_read = 1'b1; m1_read = 1'b1;
      m0_address = 18'h00023; m1_address = 18'h00041; mid();
      chk("E conf wait0", 32'(m0_waitrequest), 32'd0);
      chk("E conf wait1", 32'(m1_waitrequest), 32'd1);
      next_cyc(); idle(); mid();
      next_cyc(); idle(); mid();
      chk("E rdv0 late", 32'(m0_readdatavalid), 32'd1);
      chk("E rd0 late", m0_readdata, 32'hA0000003);

`ifdef ONCHIP_ARB_STATS_EN
      // Two conflicts, then singles, to reach 5/3/2; clear during a grant.
      next_cyc(); idle(); reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         next_cyc(); idle();
         m0_read = (c < 6); m1_read = (c < 2) || (c >= 6);
      end
      next_cyc(); idle(); stats_clear = 1'b1; m0_read = 1'b1; mid();
      chk("F m0 cnt", m0_grant_count, 32'd5);
      chk("F m1 cnt", m1_grant_count, 32'd3);
      chk("F conf cnt", conflict_count, 32'd2);
      chk("F clr wait0", 32'(m0_waitrequest), 32'd0);
      next_cyc(); idle(); mid();
      chk("F m0 clr", m0_grant_count, 32'd0);
      chk("F m1 clr", m1_grant_count, 32'd0);
      chk("F conf clr", conflict_count, 32'd0);
`endif
      repeat (3) begin next_cyc(); idle(); end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master arbiter in front of the single-port 256K x 32 on-chip RAM (M9K, single port, byte enables, unregistered q, 1-cycle read latency).
- Lets the Nios data master (m0) and the SpaceWire/DMA buffer master (m1) share the RAM at one access per clock.
- Round-robin grant, waitrequest back-pressure, pipelined reads with registered readdatavalid.
- Sits between the Avalon interconnect and the RAM's s1 port, replacing direct connection.

Parameters:
- ADDR_W, 18, word address width (262144 words).
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, 4, byteenable width = DATA_W/8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  when high, no new grants; in-flight reads complete.
- m0_address  in  ADDR_W  master 0 word address; m1_address is the same for master 1.
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  registered read data.
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read-response strobe.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  BE_W  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken; constant 1.
- mem_readdata  in  DATA_W  from RAM readdata.

Behaviour:
- Request and grant:
  - reqN = mN_read | mN_write.
  - Read and write asserted together is illegal; write wins, and this is flagged by an assertion in simulation.
- Round-robin:
  - Register last_grant; reset value 1, so m0 wins the first conflict.
  - Only one requester: that master is granted.
  - Both request: grant the master != last_grant.
  - last_grant updates only on a cycle that issues an access.
- Freeze: no grant when freeze=1.
- Combinational paths:
  - Grant and issue are combinational in cycle N.
  - mem_chipselect = granted.
  - mem_* are muxed from the granted master.
  - Ungranted masters are muxed don't-care; mem_address/mem_writedata are driven from m0 when idle.
- Waitrequest:
  - mN_waitrequest = reqN & ~grantN, combinational.
  - Deasserted when there is no request.
- Write: committed to RAM at the rising edge ending cycle N; no response.
- Read pipeline:
  - Stage 1: tag {valid, master} registered at the end of N.
  - In N+1, mem_readdata is captured into mN_readdata.
  - mN_readdatavalid is high during N+2 for exactly one cycle.
  - Fixed read latency: 2 cycles from acceptance.
- Throughput:
  - One access per cycle, back-to-back, mixed masters allowed.
  - Responses return in issue order.
- Read-during-write: same address in consecutive cycles returns post-write data (write committed before the later read samples).
- Freeze mid-operation: reads already issued still return valid data on schedule.
- Reset (synchronous):
  - Clears pipeline valids, all readdatavalid=0, readdata=0, last_grant=1.
  - An access issued in the reset cycle is discarded; reset dominates.
  - A read issued just before reset produces no readdatavalid.
- Reset values of outputs:
  - readdatavalid and readdata are 0.
  - waitrequest follows the combinational rule (freeze/reset suppress grants, so a requester sees waitrequest=1 during reset).
  - mem_clken=1.

Optional Feature:
- Macro: ONCHIP_ARB_STATS_EN.
- Defined:
  - Adds input stats_clear (1).
  - Adds outputs m0_grant_count, m1_grant_count, conflict_count (32 each).
  - Counters increment on granted access / cycle with both requesting; they saturate at 0xFFFFFFFF.
  - Cleared by reset or stats_clear; clear wins over a simultaneous increment.
- Undefined: ports and counters absent; arbitration behaviour is identical.

Test Plan:
- m0 write addr 0x00010 data 0xDEADBEEF be 0xF, then m0 read 0x00010 -> waitrequest=0 both cycles; m0_readdatavalid exactly 2 cycles after read accept with 0xDEADBEEF.
- m0 and m1 read continuously for 8 cycles, first conflict after reset -> grants alternate m0,m1,m0,...; each master gets 4 accepts; waitrequest=1 on the losing cycles; responses in order.
- m1 write be 0x3 data 0x0000AAAA over 0x12345678 at 0x3FFFF (top address), then read -> 0x1234AAAA.
- Read issued, freeze=1 next cycle with both requesting -> the issued read still returns at +2; both waitrequest=1 while frozen; after release, m0 is granted if m1 was last.
- Read accepted at cycle N, reset=1 at N+1 -> no readdatavalid at N+2; readdata=0; next conflict grants m0.
- STATS_EN: 5 m0 grants, 3 m1 grants, 2 conflicts, then stats_clear asserted in a cycle with a grant -> counts 5/3/2 before, 0/0/0 after.
